// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access engine.
package mem_access_unit_pkg;

  typedef logic [1:0] mau_state_t;

  localparam mau_state_t MAU_IDLE = 2'd0;
  localparam mau_state_t MAU_PTR  = 2'd1;
  localparam mau_state_t MAU_DATA = 2'd2;
  localparam mau_state_t MAU_RESP = 2'd3;

  // Number of address bits that select a byte lane within one data word.
  function automatic int unsigned lane_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data-memory bus bundle for mem_access_unit.
interface mem_access_unit_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MAX_IND    = 1
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IND_W = $clog2(MAX_IND + 1);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic                  req_byte;
  logic [IND_W-1:0]      req_ind;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  flush;

  logic                  resp_valid;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic                  stall;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BYTES-1:0]      mem_byte_enable;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  // The access unit's view.
  modport slave (
    input  req_valid, req_write, req_byte, req_ind, req_addr, req_wdata, flush,
    input  mem_rdata, mem_resp,
    output req_ready, resp_valid, resp_err, resp_rdata, resp_addr, stall,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );

  // The pipeline and memory side.
  modport master (
    output req_valid, req_write, req_byte, req_ind, req_addr, req_wdata, flush,
    output mem_rdata, mem_resp,
    input  req_ready, resp_valid, resp_err, resp_rdata, resp_addr, stall,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );

endinterface

// File: rtl/mem_access_unit_lane_steer.sv
// Byte-lane steering: store-side replication and lane mask, load-side byte extraction.
module mem_lane_steer #(
  parameter  int unsigned DATA_WIDTH = 16,
  localparam int unsigned BYTES      = DATA_WIDTH / 8,
  localparam int unsigned LSB        = $clog2(BYTES)
) (
  input  logic [7:0]            wbyte,
  input  logic [LSB-1:0]        lane,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] rep_data_c,
  output logic [BYTES-1:0]      lane_mask_c,
  output logic [DATA_WIDTH-1:0] load_byte_c
);

  always_comb begin
    rep_data_c  = '0;
    lane_mask_c = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      rep_data_c[i*8 +: 8] = wbyte;
      lane_mask_c[i]       = (lane == LSB'(i));
    end
    load_byte_c = DATA_WIDTH'(rdata[{lane, 3'b000} +: 8]);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine with pointer-chase indirection and byte/word sizing.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MAX_IND    = 1
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned LSB   = lane_bits(DATA_WIDTH);
  localparam int unsigned IND_W = $clog2(MAX_IND + 1);

  // Widths follow the instance parameters, so the request type lives here.
  typedef struct packed {
    logic                  write;
    logic                  byte_op;
    logic [IND_W-1:0]      ind;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } lc3b_mem_req;

  mau_state_t            state_q, state_d;
  lc3b_mem_req           req_q, req_in;
  logic                  kill_q;
  logic                  resp_valid_q, resp_err_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic [ADDR_WIDTH-1:0] resp_addr_q;

  logic                  busy, kill_now, misaligned, ptr_load, resp_load, accept;
  logic [LSB-1:0]        lane;
  logic [DATA_WIDTH-1:0] rep_data, load_byte;
  logic [BYTES-1:0]      lane_mask;

  assign busy       = (state_q == MAU_PTR) || (state_q == MAU_DATA);
  assign kill_now   = kill_q || bus.flush;
  assign lane       = req_q.addr[LSB-1:0];
  assign misaligned = !req_q.byte_op && (lane != '0);
  assign accept     = (state_q == MAU_IDLE) && bus.req_valid;

  always_comb begin
    req_in         = '0;
    req_in.write   = bus.req_write;
    req_in.byte_op = bus.req_byte;
    req_in.ind     = bus.req_ind;
    req_in.addr    = bus.req_addr;
    req_in.wdata   = bus.req_wdata;
  end

  mem_lane_steer #(.DATA_WIDTH(DATA_WIDTH)) u_steer (
    .wbyte       (req_q.wdata[7:0]),
    .lane        (lane),
    .rdata       (bus.mem_rdata),
    .rep_data_c  (rep_data),
    .lane_mask_c (lane_mask),
    .load_byte_c (load_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= MAU_IDLE;
    else       state_q <= state_d;
  end

  // Next state; a pending or same-cycle flush turns completion into a silent return to IDLE.
  always_comb begin
    state_d   = state_q;
    ptr_load  = 1'b0;
    resp_load = 1'b0;
    case (state_q)
      MAU_IDLE: begin
        if (bus.req_valid) state_d = (bus.req_ind == '0) ? MAU_DATA : MAU_PTR;
      end
      MAU_PTR: begin
        if (bus.mem_resp) begin
          ptr_load = 1'b1;
          if (kill_now)                     state_d = MAU_IDLE;
          else if (req_q.ind == IND_W'(1)) state_d = MAU_DATA;
        end
      end
      MAU_DATA: begin
        if (misaligned || bus.mem_resp) begin
          state_d   = kill_now ? MAU_IDLE : MAU_RESP;
          resp_load = !kill_now;
        end
      end
      default: state_d = MAU_IDLE;
    endcase
  end

  // Memory bus is decoded from state and captured request so it holds until mem_resp.
  always_comb begin
    bus.mem_read                = 1'b0;
    bus.mem_write               = 1'b0;
    bus.mem_wdata               = '0;
    bus.mem_byte_enable         = '0;
    bus.mem_address             = req_q.addr;
    bus.mem_address[LSB-1:0]    = '0;
    case (state_q)
      MAU_PTR: bus.mem_read = 1'b1;
      MAU_DATA: begin
        if (!misaligned) begin
          if (req_q.write) begin
            bus.mem_write       = 1'b1;
            bus.mem_wdata       = req_q.byte_op ? rep_data : req_q.wdata;
            bus.mem_byte_enable = req_q.byte_op ? lane_mask : '1;
          end else begin
            bus.mem_read = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // The captured address doubles as the pointer; the ind field counts remaining levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q        <= '0;
      kill_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      resp_addr_q  <= '0;
    end else begin
      resp_valid_q <= resp_load;
      if (accept) begin
        req_q  <= req_in;
        kill_q <= 1'b0;
      end else begin
        if (busy && bus.flush) kill_q <= 1'b1;
        if (ptr_load) begin
          req_q.addr <= bus.mem_rdata[ADDR_WIDTH-1:0];
          req_q.ind  <= req_q.ind - IND_W'(1);
        end
      end
      if (resp_load) begin
        resp_err_q  <= misaligned;
        resp_addr_q <= req_q.addr;
        if (req_q.write || misaligned) resp_rdata_q <= '0;
        else if (req_q.byte_op)        resp_rdata_q <= load_byte;
        else                           resp_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.req_ready  = (state_q == MAU_IDLE);
  assign bus.stall      = bus.req_valid && (state_q != MAU_RESP);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_addr  = resp_addr_q;

endmodule
